// File: rtl/scan_timing_gen.sv
// Raster timing and text-scan generator on clk_100mhz with a pixel clock-enable; every output is
// registered from the next counter state, so it changes together with o_pix_ce (i_en=0 freezes the block).
module scan_timing_gen #(
   parameter int   HSZ      = 10,
   parameter int   VSZ      = 10,
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   PIX_DIV  = 4,
   parameter int   GLYPH_W  = 8,
   parameter int   GLYPH_H  = 8,
   parameter int   TROW_SZ  = 6
) (
   input  logic                           clk_100mhz,
   input  logic                           rstn_i,
   input  logic                           i_en,
   input  logic                           i_scroll_we,
   input  logic [3:0]                     i_scroll,
   output logic                           o_scroll_pending,
   output logic                           o_pix_ce,
   output logic [HSZ-1:0]                 o_hcount,
   output logic [VSZ-1:0]                 o_vcount,
   output logic                           o_de,
   output logic                           o_hsync,
   output logic                           o_vsync,
   output logic                           o_line_start,
   output logic                           o_frame_start,
   output logic [$clog2(GLYPH_W)-1:0]     o_cell_col,
   output logic [HSZ-$clog2(GLYPH_W)-1:0] o_text_col,
   output logic [3:0]                     o_glyph_row,
   output logic [TROW_SZ-1:0]             o_text_row,
   output logic [15:0]                    o_frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int CW      = $clog2(GLYPH_W);
   localparam int DW      = $clog2(PIX_DIV);

   localparam logic [DW-1:0]  DIV_LAST = DW'(PIX_DIV - 1);
   localparam logic [HSZ-1:0] H_LAST   = HSZ'(H_TOTAL - 1);
   localparam logic [HSZ-1:0] H_ACT    = HSZ'(H_ACTIVE);
   localparam logic [HSZ-1:0] HS_FIRST = HSZ'(H_ACTIVE + H_FP);
   localparam logic [HSZ-1:0] HS_LAST  = HSZ'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VSZ-1:0] V_LAST   = VSZ'(V_TOTAL - 1);
   localparam logic [VSZ-1:0] V_ACT    = VSZ'(V_ACTIVE);
   localparam logic [VSZ-1:0] VS_FIRST = VSZ'(V_ACTIVE + V_FP);
   localparam logic [VSZ-1:0] VS_LAST  = VSZ'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [3:0]     G_LAST   = 4'(GLYPH_H - 1);
   localparam logic [4:0]     G_H5     = 5'(GLYPH_H);

   logic [DW-1:0]      div_q,      div_d;
   logic               pix_ce_q,   pix_ce_d;
   logic [HSZ-1:0]     h_q,        h_d;
   logic [VSZ-1:0]     v_q,        v_d;
   logic               de_q,       de_d;
   logic               hs_q,       hs_d;
   logic               vs_q,       vs_d;
   logic               line_q,     line_d;
   logic               frame_q,    frame_d;
   logic [3:0]         glyph_q,    glyph_d;
   logic [TROW_SZ-1:0] trow_q,     trow_d;
   logic [15:0]        fcnt_q,     fcnt_d;
   logic [3:0]         shadow_q,   shadow_d;
   logic [3:0]         active_q,   active_d;
   logic               pend_q,     pend_d;

   logic               advance;
   logic               h_wrap;
   logic               frame_wrap;
   logic [HSZ-1:0]     h_nx;
   logic [VSZ-1:0]     v_nx;

   always_comb begin
      div_d      = div_q;
      pix_ce_d   = 1'b0;
      h_d        = h_q;
      v_d        = v_q;
      de_d       = de_q;
      hs_d       = hs_q;
      vs_d       = vs_q;
      line_d     = 1'b0;
      frame_d    = 1'b0;
      glyph_d    = glyph_q;
      trow_d     = trow_q;
      fcnt_d     = fcnt_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      pend_d     = pend_q;
      h_wrap     = 1'b0;
      frame_wrap = 1'b0;
      h_nx       = h_q;
      v_nx       = v_q;

      advance = i_en && (div_q == DIV_LAST);

      if (i_en) begin
         div_d = advance ? '0 : div_q + 1'b1;
      end

      if (advance) begin
         h_wrap     = (h_q == H_LAST);
         frame_wrap = h_wrap && (v_q == V_LAST);
         h_nx       = h_wrap ? '0 : h_q + 1'b1;
         if (h_wrap) begin
            v_nx = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end

         // Decode the values the counters are about to take so flags line up with o_hcount/o_vcount.
         pix_ce_d = 1'b1;
         h_d      = h_nx;
         v_d      = v_nx;
         de_d     = (h_nx < H_ACT) && (v_nx < V_ACT);
         hs_d     = (h_nx >= HS_FIRST && h_nx <= HS_LAST) ? HS_POL : ~HS_POL;
         vs_d     = (v_nx >= VS_FIRST && v_nx <= VS_LAST) ? VS_POL : ~VS_POL;
         line_d   = h_wrap;
         frame_d  = frame_wrap;

         if (frame_wrap) begin
            active_d = shadow_q;
            glyph_d  = shadow_q;
            trow_d   = '0;
            fcnt_d   = fcnt_q + 16'd1;
            pend_d   = 1'b0;
         end else if (h_wrap && (v_q < V_ACT)) begin
            if (glyph_q == G_LAST) begin
               glyph_d = '0;
               trow_d  = trow_q + 1'b1;
            end else begin
               glyph_d = glyph_q + 4'd1;
            end
         end
      end

      // A write colliding with the frame transfer lands in the shadow for the following frame.
      if (i_scroll_we) begin
         shadow_d = ({1'b0, i_scroll} >= G_H5) ? G_LAST : i_scroll;
         pend_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_100mhz or negedge rstn_i) begin
      if (!rstn_i) begin
         div_q    <= '0;
         pix_ce_q <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
         de_q     <= 1'b0;
         hs_q     <= ~HS_POL;
         vs_q     <= ~VS_POL;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
         glyph_q  <= '0;
         trow_q   <= '0;
         fcnt_q   <= '0;
         shadow_q <= '0;
         active_q <= '0;
         pend_q   <= 1'b0;
      end else begin
         div_q    <= div_d;
         pix_ce_q <= pix_ce_d;
         h_q      <= h_d;
         v_q      <= v_d;
         de_q     <= de_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
         glyph_q  <= glyph_d;
         trow_q   <= trow_d;
         fcnt_q   <= fcnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         pend_q   <= pend_d;
      end
   end

   assign o_scroll_pending = pend_q;
   assign o_pix_ce         = pix_ce_q;
   assign o_hcount         = h_q;
   assign o_vcount         = v_q;
   assign o_de             = de_q;
   assign o_hsync          = hs_q;
   assign o_vsync          = vs_q;
   assign o_line_start     = line_q;
   assign o_frame_start    = frame_q;
   assign o_cell_col       = h_q[CW-1:0];
   assign o_text_col       = h_q[HSZ-1:CW];
   assign o_glyph_row      = glyph_q;
   assign o_text_row       = trow_q;
   assign o_frame_cnt      = fcnt_q;

endmodule

// File: tb/tb_scan_timing_gen.sv
// Directed bench: u_a uses a 24x16 raster (PIX_DIV=4, 4x4 glyphs, negative syncs);
// u_b uses a 24x24 raster (PIX_DIV=2, GLYPH_H=16, positive syncs).
module tb_scan_timing_gen;

   logic       clk_100mhz = 1'b0;
   logic       rstn_i;
   logic       en_a, we_a, en_b, we_b;
   logic [3:0] scr_a, scr_b;

   logic       a_pend, a_pix_ce, a_de, a_hs, a_vs, a_ls, a_fs;
   logic [4:0] a_h, a_v;
   logic [1:0] a_cell;
   logic [2:0] a_tcol, a_trow;
   logic [3:0] a_glyph;
   logic [15:0] a_fcnt;

   logic       b_pend, b_pix_ce, b_de, b_hs, b_vs, b_ls, b_fs;
   logic [4:0] b_h, b_v;
   logic [1:0] b_cell;
   logic [2:0] b_tcol, b_trow;
   logic [3:0] b_glyph;
   logic [15:0] b_fcnt;

   int checks = 0;
   int errors = 0;

   always #5 clk_100mhz = ~clk_100mhz;

   scan_timing_gen #(
      .HSZ(5), .VSZ(5), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0),
      .PIX_DIV(4), .GLYPH_W(4), .GLYPH_H(4), .TROW_SZ(3)
   ) u_a (
      .clk_100mhz(clk_100mhz), .rstn_i(rstn_i), .i_en(en_a), .i_scroll_we(we_a), .i_scroll(scr_a),
      .o_scroll_pending(a_pend), .o_pix_ce(a_pix_ce), .o_hcount(a_h), .o_vcount(a_v), .o_de(a_de),
      .o_hsync(a_hs), .o_vsync(a_vs), .o_line_start(a_ls), .o_frame_start(a_fs), .o_cell_col(a_cell),
      .o_text_col(a_tcol), .o_glyph_row(a_glyph), .o_text_row(a_trow), .o_frame_cnt(a_fcnt)
   );

   scan_timing_gen #(
      .HSZ(5), .VSZ(5), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(20), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1),
      .PIX_DIV(2), .GLYPH_W(4), .GLYPH_H(16), .TROW_SZ(3)
   ) u_b (
      .clk_100mhz(clk_100mhz), .rstn_i(rstn_i), .i_en(en_b), .i_scroll_we(we_b), .i_scroll(scr_b),
      .o_scroll_pending(b_pend), .o_pix_ce(b_pix_ce), .o_hcount(b_h), .o_vcount(b_v), .o_de(b_de),
      .o_hsync(b_hs), .o_vsync(b_vs), .o_line_start(b_ls), .o_frame_start(b_fs), .o_cell_col(b_cell),
      .o_text_col(b_tcol), .o_glyph_row(b_glyph), .o_text_row(b_trow), .o_frame_cnt(b_fcnt)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk_100mhz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the next pixel-enable cycle showing (h,v).
   task automatic wait_a(input int h, input int v, input string tag);
      int n;
      n = 0;
      tick(1);
      while (!(a_pix_ce === 1'b1 && int'(a_h) == h && int'(a_v) == v) && n < 4000) begin
         tick(1);
         n++;
      end
      chk({tag, "_reached"}, 32'(n < 4000), 32'd1);
   endtask

   task automatic wait_b(input int h, input int v, input string tag);
      int n;
      n = 0;
      tick(1);
      while (!(b_pix_ce === 1'b1 && int'(b_h) == h && int'(b_v) == v) && n < 4000) begin
         tick(1);
         n++;
      end
      chk({tag, "_reached"}, 32'(n < 4000), 32'd1);
   endtask

   initial begin
      int clocks, npix, nde, nbad, nhs, nvs, nfrz;

      rstn_i = 1'b0;
      en_a = 1'b1; we_a = 1'b0; scr_a = 4'd0;
      en_b = 1'b1; we_b = 1'b0; scr_b = 4'd0;
      tick(3);

      // Reset state
      chk("rst_h", a_h, 0);            chk("rst_v", a_v, 0);
      chk("rst_pix_ce", a_pix_ce, 0);  chk("rst_de", a_de, 0);
      chk("rst_hs", a_hs, 1);          chk("rst_vs", a_vs, 1);
      chk("rst_ls", a_ls, 0);          chk("rst_fs", a_fs, 0);
      chk("rst_pend", a_pend, 0);      chk("rst_glyph", a_glyph, 0);
      chk("rst_trow", a_trow, 0);      chk("rst_fcnt", a_fcnt, 0);
      chk("rst_b_hs", b_hs, 0);        chk("rst_b_vs", b_vs, 0);

      rstn_i = 1'b1;
      tick(2);
      chk("a_ce_early", a_pix_ce, 0);  chk("a_de_early", a_de, 0);
      chk("b_ce_first", b_pix_ce, 1);  chk("b_h_first", b_h, 1);
      tick(1);
      chk("a_ce_div3", a_pix_ce, 0);   chk("b_ce_gap", b_pix_ce, 0);
      tick(1);
      chk("a_ce_first", a_pix_ce, 1);  chk("a_h_first", a_h, 1);
      chk("a_v_first", a_v, 0);        chk("a_de_first", a_de, 1);
      chk("b_ce_second", b_pix_ce, 1); chk("b_h_second", b_h, 2);
      tick(1);
      chk("a_ce_width", a_pix_ce, 0);
      tick(3);
      chk("a_ce_period", a_pix_ce, 1); chk("a_h_period", a_h, 2);

      // Horizontal decode
      wait_a(13, 0, "h13");
      chk("tcol13", a_tcol, 3);        chk("cell13", a_cell, 1);
      chk("de13", a_de, 1);            chk("hs13", a_hs, 1);
      wait_a(16, 0, "h16");
      chk("de16", a_de, 0);            chk("hs16", a_hs, 1);
      wait_a(17, 0, "h17");            chk("hs17", a_hs, 1);
      wait_a(18, 0, "h18");            chk("hs18", a_hs, 0);
      wait_a(20, 0, "h20");            chk("hs20", a_hs, 0);
      wait_a(21, 0, "h21");            chk("hs21", a_hs, 1);
      wait_a(0, 1, "v1");
      chk("ls_v1", a_ls, 1);           chk("fs_v1", a_fs, 0);
      chk("glyph_v1", a_glyph, 1);     chk("trow_v1", a_trow, 0);
      chk("de_v1", a_de, 1);           chk("vs_v1", a_vs, 1);

      clocks = 0;
      do begin
         tick(1);
         clocks++;
      end while (a_ls !== 1'b1 && clocks < 200);
      chk("line_period", clocks, 96);

      // Text scan
      wait_a(0, 4, "v4");
      chk("glyph_v4", a_glyph, 0);     chk("trow_v4", a_trow, 1);
      wait_a(0, 5, "v5");
      tick(1);
      we_a = 1'b1; scr_a = 4'd3;
      tick(1);
      we_a = 1'b0;
      chk("pend_set", a_pend, 1);
      wait_a(0, 11, "v11");
      chk("glyph_v11", a_glyph, 3);    chk("trow_v11", a_trow, 2);
      wait_a(0, 12, "v12");
      chk("glyph_v12", a_glyph, 0);    chk("trow_v12", a_trow, 3);
      chk("de_v12", a_de, 0);
      wait_a(0, 13, "v13");
      chk("vs_v13", a_vs, 0);          chk("glyph_v13", a_glyph, 0);
      chk("trow_v13", a_trow, 3);
      wait_a(23, 14, "v14");           chk("vs_v14", a_vs, 0);
      wait_a(0, 15, "v15");            chk("vs_v15", a_vs, 1);

      // Frame 1 start applies scroll 3
      wait_a(0, 0, "f1");
      chk("f1_fs", a_fs, 1);           chk("f1_ls", a_ls, 1);
      chk("f1_fcnt", a_fcnt, 1);       chk("f1_pend", a_pend, 0);
      chk("f1_glyph", a_glyph, 3);     chk("f1_trow", a_trow, 0);
      chk("f1_de", a_de, 1);

      clocks = 0; npix = 0; nde = 0; nbad = 0; nhs = 0; nvs = 0;
      do begin
         if (a_pix_ce === 1'b1) begin
            npix++;
            if (a_de === 1'b1) nde++;
            if (a_hs === 1'b0) nhs++;
            if (a_vs === 1'b0) nvs++;
         end
         if (a_de === 1'b1 && (a_h >= 5'd16 || a_v >= 5'd12)) nbad++;
         tick(1);
         clocks++;
      end while (a_fs !== 1'b1 && clocks < 3000);
      chk("frame_clocks", clocks, 1536);
      chk("frame_pix", npix, 384);
      chk("frame_de", nde, 192);
      chk("de_outside", nbad, 0);
      chk("hs_pixels", nhs, 48);
      chk("vs_pixels", nvs, 48);
      chk("f2_fs", a_fs, 1);           chk("f2_fcnt", a_fcnt, 2);
      chk("f2_glyph", a_glyph, 3);     chk("f2_pend", a_pend, 0);
      wait_a(0, 1, "f2_v1");
      chk("f2_glyph_v1", a_glyph, 0);  chk("f2_trow_v1", a_trow, 1);

      // Last write wins, clamp, and a write colliding with the transfer
      wait_a(0, 6, "f2_v6");
      we_a = 1'b1; scr_a = 4'd1;
      tick(1);
      we_a = 1'b0;
      tick(2);
      we_a = 1'b1; scr_a = 4'd12;
      tick(1);
      we_a = 1'b0;
      chk("f2_pend", a_pend, 1);
      wait_a(23, 15, "f2_end");
      tick(3);
      we_a = 1'b1; scr_a = 4'd0;
      tick(1);
      we_a = 1'b0;
      chk("f3_fs", a_fs, 1);           chk("f3_fcnt", a_fcnt, 3);
      chk("f3_glyph_clamp", a_glyph, 3);
      chk("f3_pend_kept", a_pend, 1);
      wait_a(0, 0, "f4");
      chk("f4_fcnt", a_fcnt, 4);       chk("f4_glyph", a_glyph, 0);
      chk("f4_pend", a_pend, 0);

      // Enable freeze mid-line
      wait_a(5, 3, "frz");
      tick(2);
      en_a = 1'b0;
      nfrz = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (a_pix_ce !== 1'b0) nfrz++;
      end
      chk("frz_ce", nfrz, 0);
      chk("frz_h", a_h, 5);            chk("frz_v", a_v, 3);
      chk("frz_glyph", a_glyph, 3);    chk("frz_trow", a_trow, 0);
      chk("frz_de", a_de, 1);
      en_a = 1'b1;
      tick(1);
      chk("resume_ce0", a_pix_ce, 0);  chk("resume_h0", a_h, 5);
      tick(1);
      chk("resume_ce1", a_pix_ce, 1);  chk("resume_h1", a_h, 6);

      // Asynchronous reset mid-frame drops a pending write
      we_a = 1'b1; scr_a = 4'd2;
      tick(1);
      we_a = 1'b0;
      chk("pre_rst_pend", a_pend, 1);
      wait_a(10, 7, "pre_rst");
      #2;
      rstn_i = 1'b0;
      #1;
      chk("arst_h", a_h, 0);           chk("arst_v", a_v, 0);
      chk("arst_ce", a_pix_ce, 0);     chk("arst_de", a_de, 0);
      chk("arst_hs", a_hs, 1);         chk("arst_vs", a_vs, 1);
      chk("arst_ls", a_ls, 0);         chk("arst_fs", a_fs, 0);
      chk("arst_pend", a_pend, 0);     chk("arst_glyph", a_glyph, 0);
      chk("arst_trow", a_trow, 0);     chk("arst_fcnt", a_fcnt, 0);
      chk("arst_b_h", b_h, 0);         chk("arst_b_hs", b_hs, 0);
      @(posedge clk_100mhz);
      #1;
      rstn_i = 1'b1;
      tick(3);
      chk("rerun_ce0", a_pix_ce, 0);
      tick(1);
      chk("rerun_ce1", a_pix_ce, 1);   chk("rerun_h", a_h, 1);
      chk("rerun_glyph", a_glyph, 0);  chk("rerun_pend", a_pend, 0);

      // Positive sync polarity, PIX_DIV=2, 16-line glyphs
      wait_b(17, 0, "b_h17");          chk("b_hs17", b_hs, 0);
      wait_b(18, 0, "b_h18");          chk("b_hs18", b_hs, 1);
      wait_b(20, 0, "b_h20");          chk("b_hs20", b_hs, 1);
      wait_b(21, 0, "b_h21");          chk("b_hs21", b_hs, 0);
      wait_b(0, 15, "b_v15");
      chk("b_glyph_v15", b_glyph, 15); chk("b_trow_v15", b_trow, 0);
      wait_b(0, 16, "b_v16");
      chk("b_glyph_v16", b_glyph, 0);  chk("b_trow_v16", b_trow, 1);
      chk("b_de_v16", b_de, 1);        chk("b_vs_v16", b_vs, 0);
      tick(1);
      chk("b_ce_gap2", b_pix_ce, 0);
      tick(1);
      chk("b_ce_next", b_pix_ce, 1);   chk("b_h_next", b_h, 1);
      wait_b(0, 21, "b_v21");
      chk("b_vs_v21", b_vs, 1);        chk("b_de_v21", b_de, 0);
      chk("b_glyph_v21", b_glyph, 4);  chk("b_trow_v21", b_trow, 1);
      wait_b(0, 23, "b_v23");          chk("b_vs_v23", b_vs, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
